uart_tx_arbiter: RTL

Round-robin, packet-locked arbiter that shares one serial transmitter between several byte-stream requesters (debug console, trace dump, boot messages). It sits directly in front of the transmitter's valid/ready byte input and guarantees that a multi-byte message from one requester is never interleaved with bytes from another. A single output register decouples requester timing from the transmitter. An idle-timeout releases the lock if a requester stalls mid-message.

---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding one serial transmitter's byte input.
// A locked owner keeps the transmitter until its last byte or an idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [GW-1:0]                 grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_ptr, w_ptr_nxt;
  logic [GW-1:0]         r_grant, w_grant_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_tx_valid, w_tx_valid_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  r_timeout, w_timeout_nxt;

  logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]    w_ready;
  logic [GW-1:0]         w_idx;
  logic [GW-1:0]         w_pick;
  logic                  w_any_req;
  logic [GW-1:0]         w_ptr_after_g;
  logic                  w_buf_free;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_accept;

  // Unflatten requester bytes and pick the first valid requester at or after ptr.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = r_ptr;
    w_idx     = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_req_bytes[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    // Scan from the farthest offset down so the nearest match to ptr wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = GW'((int'(r_ptr) + i) % NUM_REQ);
      if (req_valid_i[w_idx]) begin
        w_any_req = 1'b1;
        w_pick    = w_idx;
      end else begin
        w_any_req = w_any_req;
      end
    end
  end

  assign w_buf_free    = !r_tx_valid || tx_ready_i;
  assign w_owner_valid = req_valid_i[r_grant];
  assign w_owner_last  = req_last_i[r_grant];
  assign w_accept      = (r_state == S_LOCKED) && w_owner_valid && w_buf_free;
  assign w_ptr_after_g = (r_grant == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : r_grant + GW'(1);

  // Only the owner sees ready, and only when the output register can take a byte.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ready[k] = (r_state == S_LOCKED) && (r_grant == GW'(k)) && w_buf_free;
    end
  end

  // Next-state logic for the lock FSM, round-robin pointer and idle-timeout counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = {CW{1'b0}};
        if (w_any_req) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_LOCKED;
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      S_LOCKED: begin
        if (w_accept) begin
          w_cnt_nxt = {CW{1'b0}};
          if (w_owner_last) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_ptr_after_g;
          end else begin
            w_state_nxt = S_LOCKED;
          end
        end else if (TO_EN && !w_owner_valid) begin
          if (r_cnt == TO_LAST) begin
            w_state_nxt   = S_IDLE;
            w_ptr_nxt     = w_ptr_after_g;
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = {CW{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          // Owner is valid but stalled by the transmitter: hold the count.
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Output register: load on accept, drain on transmitter handshake, else hold.
  always_comb begin
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    if (w_accept) begin
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = w_req_bytes[r_grant];
    end else if (r_tx_valid && tx_ready_i) begin
      w_tx_valid_nxt = 1'b0;
      w_tx_data_nxt  = {DATA_WIDTH{1'b0}};
    end else begin
      w_tx_valid_nxt = r_tx_valid;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ptr      <= {GW{1'b0}};
      r_grant    <= {GW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_tx_valid <= 1'b0;
      r_tx_data  <= {DATA_WIDTH{1'b0}};
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign req_ready_o = w_ready;
  assign tx_valid_o  = r_tx_valid;
  assign tx_data_o   = r_tx_data;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == S_LOCKED);
  assign timeout_o   = r_timeout;

endmodule
